huffman_block_sequencer: RTL and testbench
==========================================

# huffman_block_sequencer

Parametrised block-level sequencer for the JPEG Huffman path, successor to the single-channel DC/AC controller. It accepts one zigzag-ordered coefficient block per handshake from the quantiser/zigzag stage and keeps a DC predictor per colour channel. It performs the AC run-length scan itself, including ZRL and EOB insertion. It emits a stream of (run, size, amplitude) symbols under valid/ready to the Huffman table lookup and bit packer.

## Interface
- COEF_W, 10: signed coefficient width, two's complement; legal range 2..14.
- NCOEF, 64: coefficients per block; legal range 2..64.
- NCH, 3: colour channels with independent DC predictors; 0 = Y, 1 = Cb, 2 = Cr.
- CH_W, derived: max(1, $clog2(NCH)).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  block offered.
- blk_ready  out  1  sequencer can accept a block.
- blk_coef  in  NCOEF*COEF_W  coefficient k at [k*COEF_W +: COEF_W]; k = 0 is DC.
- blk_chan  in  CH_W  channel of the offered block.
- dc_clear  in  1  restart-interval pulse; clears all DC predictors.
- sym_valid  out  1  symbol present.
- sym_ready  in  1  downstream accepts the symbol.
- sym_is_dc  out  1  symbol is the DC symbol.
- sym_run  out  4  zero run (AC only; 0 for DC).
- sym_size  out  4  magnitude category.
- sym_amp  out  COEF_W+1  amplitude bits, LSB-aligned, zero above sym_size.
- sym_chan  out  CH_W  channel of the current block.
- sym_last  out  1  final symbol of the block.
- busy  out  1  block in progress (state != IDLE).

## Operation
- States: IDLE, DC, SCAN, ZRL, AC, EOB.
- **IDLE:** blk_ready = 1. On blk_valid & blk_ready:
  - register blk_coef and blk_chan;
  - set run = 0, k = 1;
  - go to DC.
- **DC:**
  - diff = coef[0] − pred[chan], computed at COEF_W+1 bits.
  - Emit the DC symbol with size = category(diff).
  - On handshake: pred[chan] ← coef[0], then go to SCAN.
- **SCAN:** examine coef[k], one index per cycle.
  - Zero: run++.
  - Nonzero: go to ZRL if run ≥ 16, else go to AC.
  - After index NCOEF−1 with no symbol pending, go to EOB if run > 0; otherwise the block is complete.
- **ZRL:** emit (run=15, size=0, amp=0). On handshake, run −= 16; stay in ZRL while run ≥ 16, else go to AC.
- **AC:** emit (run, category(coef[k]), amp). On handshake, run = 0 and k++.
  - If k was NCOEF−1, the block is complete; otherwise return to SCAN.
- **EOB:** emit (0, 0, 0) with sym_last = 1. On handshake, return to IDLE.
- Trailing zero runs never emit ZRL; pending ZRLs are discarded when EOB is selected.
- sym_last = 1 on the AC symbol at index NCOEF−1 when that coefficient is nonzero; the block then ends without EOB.
- Arithmetic rules:
  - category(v) = bit length of |v|; category(0) = 0.
  - amp = v for v ≥ 0, and v − 1 for v < 0, truncated to sym_size bits.
- **dc_clear:** honoured only in IDLE; it sets all pred to 0. If it coincides with a block acceptance, the clear takes effect first and that block predicts from 0. dc_clear in any other state is ignored.

## Timing
- All outputs are registered.
- Reset values: blk_ready = 0 while reset_n = 0, and 1 in IDLE after reset. All other outputs are 0, and all pred are 0.
- sym_valid rises the cycle after block acceptance (DC symbol).
- A symbol holds sym_* stable until sym_ready is high. The next symbol is valid no earlier than the following cycle.
- Each zero coefficient costs one SCAN cycle. Worst case per block, with sym_ready tied high: 1 + (NCOEF−1) + symbols + 1 cycles.
- blk_ready reasserts the cycle after the sym_last handshake.
- sym_ready held low stalls indefinitely with no loss.
- Reset mid-block discards the block and clears the predictors.

## Configuration
- HUFF_SEQ_DC_PRED_EN defined: DC differential prediction as described, with a pred register per channel.
- Not defined:
  - no pred registers exist;
  - dc_clear is ignored;
  - the DC symbol carries raw coef[0] (category/amp rules unchanged), leaving prediction to the downstream stage.

## Test plan
- Y block, coef[0] = 20, all AC zero, pred 0, sym_ready = 1 -> DC (size 5, amp 10100), then EOB with sym_last = 1; next Y block with coef[0] = 18 -> DC diff −2 (size 2, amp 01).
- AC: coef[1] = −1, coef[20] = 3, rest zero -> (0, 1, 0), then ZRL (15, 0), then (2, 2, 11), then EOB.
- coef[63] = 1 only (NCOEF = 64) -> DC, ZRL ×3, (14, 1, 1) with sym_last = 1, no EOB.
- sym_ready toggled pseudo-randomly on the previous block -> identical symbol sequence; outputs stable while stalled; blk_ready low until after the sym_last handshake.
- Interleaved channels Y/Cb/Cr with coef[0] = 5/7/9, then dc_clear together with the next Y block (coef[0] = 5) -> predictors remain separate per channel; the Y DC diff is 5, not 0.
- reset_n asserted during SCAN of a block -> all outputs go to 0 at once; after release the next block predicts from 0.

Source files
------------

// File: rtl/huffman_block_sequencer.sv
// JPEG Huffman block sequencer: DC symbol, AC run-length scan with ZRL/EOB insertion.
// Define HUFF_SEQ_DC_PRED_EN to enable per-channel DC differential prediction.
module huffman_block_sequencer #(
  parameter int COEF_W = 10,
  parameter int NCOEF  = 64,
  parameter int NCH    = 3,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [NCOEF*COEF_W-1:0] blk_coef,
  input  logic [CH_W-1:0]         blk_chan,
  input  logic                    dc_clear,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_is_dc,
  output logic [3:0]              sym_run,
  output logic [3:0]              sym_size,
  output logic [COEF_W:0]         sym_amp,
  output logic [CH_W-1:0]         sym_chan,
  output logic                    sym_last,
  output logic                    busy
);

  localparam int K_W   = ($clog2(NCOEF) > 1) ? $clog2(NCOEF) : 1;
  localparam int RUN_W = ($clog2(NCOEF) + 1 > 5) ? $clog2(NCOEF) + 1 : 5;
  localparam logic [K_W-1:0]   K_LAST = K_W'(NCOEF - 1);
  localparam logic [RUN_W-1:0] RUN_16 = RUN_W'(16);

  typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, AC, EOB} state_t;

  state_t                  state, state_nx;
  logic [RUN_W-1:0]        run, run_nx;
  logic [K_W-1:0]          k, k_nx;
  logic signed [COEF_W-1:0] coef_q [NCOEF];
  logic signed [COEF_W-1:0] coef_k;
  logic signed [COEF_W:0]   dc_val, sym_val;
  logic                    accept, handshake;
  logic                    valid_nx, is_dc_nx, last_nx;
  logic [3:0]              run_sym_nx, size_nx;
  logic [COEF_W:0]         amp_nx;

  // Bit length of |v|; the widest possible magnitude still fits COEF_W+1 bits.
  function automatic logic [3:0] category(input logic signed [COEF_W:0] v);
    logic [COEF_W:0] mag;
    category = '0;
    mag = v[COEF_W] ? -v : v;
    for (int i = 0; i <= COEF_W; i++)
      if (mag[i]) category = 4'(i + 1);
  endfunction

  function automatic logic [COEF_W:0] amplitude(input logic signed [COEF_W:0] v,
                                                input logic [3:0] size);
    logic [COEF_W:0] raw;
    raw = v[COEF_W] ? v - (COEF_W+1)'(1) : v;
    amplitude = raw & ~({(COEF_W+1){1'b1}} << size);
  endfunction

  assign accept    = blk_valid && blk_ready;
  assign handshake = sym_valid && sym_ready;
  assign coef_k    = coef_q[k];

  // NOTE: the block buffer has no reset; every entry is written on acceptance before it is read.
  always_ff @(posedge clock) begin
    if (accept)
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= blk_coef[i*COEF_W +: COEF_W];
  end

`ifdef HUFF_SEQ_DC_PRED_EN
  logic signed [COEF_W-1:0] pred [NCH];
  logic signed [COEF_W-1:0] pred_sel;

  // A clear coinciding with acceptance makes the new block predict from zero.
  assign pred_sel = dc_clear ? '0 : pred[blk_chan];
  assign dc_val   = {blk_coef[COEF_W-1], blk_coef[COEF_W-1:0]} - {pred_sel[COEF_W-1], pred_sel};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) pred[i] <= '0;
    end else if (state == IDLE && dc_clear) begin
      for (int i = 0; i < NCH; i++) pred[i] <= '0;
    end else if (state == DC && handshake) begin
      pred[sym_chan] <= coef_q[0];
    end
  end
`else
  logic unused_dc_clear;
  assign unused_dc_clear = dc_clear;
  assign dc_val = {blk_coef[COEF_W-1], blk_coef[COEF_W-1:0]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      run   <= '0;
      k     <= '0;
    end else begin
      state <= state_nx;
      run   <= run_nx;
      k     <= k_nx;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    run_nx   = run;
    k_nx     = k;
    unique case (state)
      IDLE: if (accept) begin
        state_nx = DC;
        run_nx   = '0;
        k_nx     = K_W'(1);
      end
      DC: if (handshake) state_nx = SCAN;
      SCAN: begin
        if (coef_k == '0) begin
          if (k == K_LAST) begin
            state_nx = EOB;
          end else begin
            run_nx = run + RUN_W'(1);
            k_nx   = k + K_W'(1);
          end
        end else begin
          state_nx = (run >= RUN_16) ? ZRL : AC;
        end
      end
      ZRL: if (handshake) begin
        run_nx   = run - RUN_16;
        state_nx = (run_nx >= RUN_16) ? ZRL : AC;
      end
      AC: if (handshake) begin
        run_nx = '0;
        if (k == K_LAST) begin
          state_nx = IDLE;
        end else begin
          k_nx     = k + K_W'(1);
          state_nx = SCAN;
        end
      end
      EOB: if (handshake) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Symbol for the state being entered; AC always refers to the current k.
  always_comb begin
    valid_nx   = 1'b0;
    is_dc_nx   = 1'b0;
    last_nx    = 1'b0;
    run_sym_nx = '0;
    size_nx    = '0;
    sym_val    = {coef_k[COEF_W-1], coef_k};
    unique case (state_nx)
      DC: begin
        valid_nx = 1'b1;
        is_dc_nx = 1'b1;
        sym_val  = dc_val;
        size_nx  = category(sym_val);
      end
      ZRL: begin
        valid_nx   = 1'b1;
        run_sym_nx = 4'd15;
      end
      AC: begin
        valid_nx   = 1'b1;
        run_sym_nx = run_nx[3:0];
        size_nx    = category(sym_val);
        last_nx    = (k == K_LAST);
      end
      EOB: begin
        valid_nx = 1'b1;
        last_nx  = 1'b1;
      end
      default: ;
    endcase
    amp_nx = amplitude(sym_val, size_nx);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_ready <= 1'b0;
      busy      <= 1'b0;
      sym_valid <= 1'b0;
      sym_is_dc <= 1'b0;
      sym_run   <= '0;
      sym_size  <= '0;
      sym_amp   <= '0;
      sym_chan  <= '0;
      sym_last  <= 1'b0;
    end else begin
      blk_ready <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
      if (accept) sym_chan <= blk_chan;
      if (!sym_valid || sym_ready) begin
        sym_valid <= valid_nx;
        sym_is_dc <= is_dc_nx;
        sym_run   <= run_sym_nx;
        sym_size  <= size_nx;
        sym_amp   <= amp_nx;
        sym_last  <= last_nx;
      end
    end
  end

endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Scoreboard bench for huffman_block_sequencer; DC expectations follow HUFF_SEQ_DC_PRED_EN.
module tb_huffman_block_sequencer;

  localparam int COEF_W = 10;
  localparam int NCOEF  = 64;
  localparam int NCH    = 3;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic            is_dc;
    logic [3:0]      run;
    logic [3:0]      size;
    logic [COEF_W:0] amp;
    logic [CH_W-1:0] chan;
    logic            last;
  } sym_t;

  logic                    clock, reset_n;
  logic                    blk_valid, blk_ready;
  logic [NCOEF*COEF_W-1:0] blk_coef;
  logic [CH_W-1:0]         blk_chan;
  logic                    dc_clear;
  logic                    sym_valid, sym_ready, sym_is_dc;
  logic [3:0]              sym_run, sym_size;
  logic [COEF_W:0]         sym_amp;
  logic [CH_W-1:0]         sym_chan;
  logic                    sym_last, busy;

  sym_t                    exp_q[$];
  int                      n_checks = 0;
  int                      n_errors = 0;
  logic                    rand_ready = 1'b0;
  logic [NCOEF*COEF_W-1:0] vec;

  huffman_block_sequencer #(.COEF_W(COEF_W), .NCOEF(NCOEF), .NCH(NCH)) dut (
    .clock(clock), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_coef(blk_coef),
    .blk_chan(blk_chan), .dc_clear(dc_clear),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .sym_chan(sym_chan), .sym_last(sym_last), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic sym_t dut_sym();
    sym_t s;
    s.is_dc = sym_is_dc;
    s.run   = sym_run;
    s.size  = sym_size;
    s.amp   = sym_amp;
    s.chan  = sym_chan;
    s.last  = sym_last;
    return s;
  endfunction

  task automatic push(input logic is_dc, input int run, input int size, input int amp,
                      input int chan, input logic last);
    sym_t s;
    s.is_dc = is_dc;
    s.run   = 4'(run);
    s.size  = 4'(size);
    s.amp   = (COEF_W+1)'(amp);
    s.chan  = CH_W'(chan);
    s.last  = last;
    exp_q.push_back(s);
  endtask

  // (ps, pa) with prediction enabled, (rs, ra) for raw coef[0].
  task automatic push_dc(input int chan, input int ps, input int pa, input int rs, input int ra);
`ifdef HUFF_SEQ_DC_PRED_EN
    push(1'b1, 0, ps, pa, chan, 1'b0);
`else
    push(1'b1, 0, rs, ra, chan, 1'b0);
`endif
  endtask

  task automatic push_eob(input int chan);
    push(1'b0, 0, 0, 0, chan, 1'b1);
  endtask

  task automatic set_coef(input int idx, input int v);
    logic [31:0] t;
    t = v;
    vec[idx*COEF_W +: COEF_W] = t[COEF_W-1:0];
  endtask

  task automatic send_block(input int chan, input logic clear);
    int waited = 0;
    while (!blk_ready && waited < 1000) begin
      @(posedge clock); #1;
      waited++;
    end
    check("blk_ready_wait", 32'(blk_ready), 32'(1));
    blk_coef  = vec;
    blk_chan  = CH_W'(chan);
    dc_clear  = clear;
    blk_valid = 1'b1;
    @(posedge clock); #1;
    blk_valid = 1'b0;
    dc_clear  = 1'b0;
    check("dc_latency", 32'(sym_valid), 32'(1));
    check("busy_after_accept", 32'(busy), 32'(1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain", 32'(exp_q.size() == 0 && !busy), 32'(1));
  endtask

  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      sym_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every handshaked symbol and the stall / blk_ready rules.
  initial begin
    logic stall_prev, last_hs_prev;
    sym_t held, cur, e;
    int   idx;
    stall_prev   = 1'b0;
    last_hs_prev = 1'b0;
    held         = '0;
    idx          = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stall_prev   = 1'b0;
        last_hs_prev = 1'b0;
      end else begin
        cur = dut_sym();
        if (last_hs_prev) check("blk_ready_after_last", 32'(blk_ready), 32'(1));
        if (stall_prev) begin
          check("stall_valid", 32'(sym_valid), 32'(1));
          check("stall_hold", 32'(cur), 32'(held));
        end
        if (sym_valid) check("blk_ready_while_busy", 32'(blk_ready), 32'(0));
        if (sym_valid && sym_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sym_unexpected: got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("sym[%0d]", idx), 32'(cur), 32'(e));
          end
          idx++;
        end
        stall_prev   = sym_valid && !sym_ready;
        held         = cur;
        last_hs_prev = sym_valid && sym_ready && sym_last;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    blk_valid = 1'b0;
    blk_coef  = '0;
    blk_chan  = '0;
    dc_clear  = 1'b0;
    vec       = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_blk_ready", 32'(blk_ready), 32'(0));
    check("rst_sym_valid", 32'(sym_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sym_fields", 32'(dut_sym()), 32'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_blk_ready", 32'(blk_ready), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));

    // Y, DC only: 20 then 18 (diff -2 -> size 2, amp 01).
    vec = '0; set_coef(0, 20);
    push_dc(0, 5, 20, 5, 20); push_eob(0);
    send_block(0, 1'b0); drain();
    vec = '0; set_coef(0, 18);
    push_dc(0, 2, 1, 5, 18); push_eob(0);
    send_block(0, 1'b0); drain();

    // AC: coef[1] = -1, coef[20] = 3.
    vec = '0; set_coef(0, 18); set_coef(1, -1); set_coef(20, 3);
    push_dc(0, 0, 0, 5, 18);
    push(1'b0, 0, 1, 0, 0, 1'b0);
    push(1'b0, 15, 0, 0, 0, 1'b0);
    push(1'b0, 2, 2, 3, 0, 1'b0);
    push_eob(0);
    send_block(0, 1'b0); drain();

    // Only coef[63] = 1: three ZRLs, final AC carries sym_last, no EOB.
    vec = '0; set_coef(0, 18); set_coef(63, 1);
    push_dc(0, 0, 0, 5, 18);
    for (int i = 0; i < 3; i++) push(1'b0, 15, 0, 0, 0, 1'b0);
    push(1'b0, 14, 1, 1, 0, 1'b1);
    send_block(0, 1'b0); drain();

    // Same AC block under random back-pressure.
    rand_ready = 1'b1;
    vec = '0; set_coef(0, 18); set_coef(1, -1); set_coef(20, 3);
    push_dc(0, 0, 0, 5, 18);
    push(1'b0, 0, 1, 0, 0, 1'b0);
    push(1'b0, 15, 0, 0, 0, 1'b0);
    push(1'b0, 2, 2, 3, 0, 1'b0);
    push_eob(0);
    send_block(0, 1'b0); drain();
    rand_ready = 1'b0;
    @(posedge clock); #1;

    // Standalone clear, then interleaved channels.
    dc_clear = 1'b1;
    @(posedge clock); #1;
    dc_clear = 1'b0;
    vec = '0; set_coef(0, 5); push_dc(0, 3, 5, 3, 5); push_eob(0); send_block(0, 1'b0);
    vec = '0; set_coef(0, 7); push_dc(1, 3, 7, 3, 7); push_eob(1); send_block(1, 1'b0);
    vec = '0; set_coef(0, 9); push_dc(2, 4, 9, 4, 9); push_eob(2); send_block(2, 1'b0);
    vec = '0; set_coef(0, 8); push_dc(1, 1, 1, 4, 8); push_eob(1); send_block(1, 1'b0);
    vec = '0; set_coef(0, 5); push_dc(0, 3, 5, 3, 5); push_eob(0); send_block(0, 1'b1);
    vec = '0; set_coef(0, 9); push_dc(2, 4, 9, 4, 9); push_eob(2); send_block(2, 1'b0);
    drain();

    // Reset in the middle of SCAN.
    vec = '0; set_coef(0, 12); set_coef(63, 1);
    push_dc(0, 3, 7, 4, 12);
    send_block(0, 1'b0);
    repeat (8) @(posedge clock);
    #1;
    check("pre_reset_q_empty", 32'(exp_q.size()), 32'(0));
    check("pre_reset_busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_blk_ready", 32'(blk_ready), 32'(0));
    check("mid_rst_sym_valid", 32'(sym_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_sym_fields", 32'(dut_sym()), 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_rst_blk_ready", 32'(blk_ready), 32'(1));
    vec = '0; set_coef(0, 5);
    push_dc(0, 3, 5, 3, 5); push_eob(0);
    send_block(0, 1'b0); drain();

    check("final_q_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
